// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 timing, total derivations
// and counter/coordinate widths used by vga_timing_gen and its bench.
package vga_pkg;

    localparam int unsigned H_CNT_W = 10;
    localparam int unsigned V_CNT_W = 10;
    localparam int unsigned X_W     = 10;
    localparam int unsigned Y_W     = 9;

    localparam int unsigned DEF_CLK_DIV   = 4;
    localparam int unsigned DEF_H_DISPLAY = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_DISPLAY = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    // Total period of one axis: display + front porch + sync + back porch
    function automatic int unsigned span_total(input int unsigned disp,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
        return disp + front + sync + back;
    endfunction

    localparam int unsigned DEF_H_TOTAL =
        span_total(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int unsigned DEF_V_TOTAL =
        span_total(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel clock-enable divider: counts 0..CLK_DIV-1 and pulses p_tick for one
// clk while the count sits at CLK_DIV-1.
// Ports: clk, reset (sync, active-high), p_tick (one-clk pixel enable).
module pixel_tick_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_count;

    assign p_tick = (div_count == DIV_W'(CLK_DIV - 1));

    // Free-running divider, wraps after the tick cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            div_count <= '0;
        end else if (p_tick) begin
            div_count <= '0;
        end else begin
            div_count <= div_count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel divider, horizontal/vertical counters and
// decoded sync, active-video and coordinate outputs.
// Ports: clk, reset (sync, active-high); outputs p_tick, hsync/vsync (active
// low), video_on, x[9:0], y[8:0], frame_tick.
// Build option: define VGA_SYNC_PIPE_EN to delay hsync/vsync by 2 clk so they
// line up with the 2-register image ROM address-to-color path.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK
) (
    input  logic           clk,
    input  logic           reset,
    output logic           p_tick,
    output logic           hsync,
    output logic           vsync,
    output logic           video_on,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           frame_tick
);

    localparam int unsigned H_TOTAL  = span_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL  = span_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned HS_FIRST = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_LAST  = H_DISPLAY + H_FRONT + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_LAST  = V_DISPLAY + V_FRONT + V_SYNC - 1;

    logic [H_CNT_W-1:0] h_count;
    logic [V_CNT_W-1:0] v_count;
    logic               h_end;
    logic               v_end;
    logic               hsync_raw;
    logic               vsync_raw;

    pixel_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_tick_gen (
        .clk   (clk),
        .reset (reset),
        .p_tick(p_tick)
    );

    assign h_end = (h_count == H_CNT_W'(H_TOTAL - 1));
    assign v_end = (v_count == V_CNT_W'(V_TOTAL - 1));

    // Raster position: h advances every pixel, v at the end of each line
    always_ff @(posedge clk) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (p_tick) begin
            if (h_end) begin
                h_count <= '0;
                if (v_end) begin
                    v_count <= '0;
                end else begin
                    v_count <= v_count + V_CNT_W'(1);
                end
            end else begin
                h_count <= h_count + H_CNT_W'(1);
            end
        end
    end

    assign frame_tick = p_tick & h_end & v_end;

    assign video_on = (h_count < H_CNT_W'(H_DISPLAY)) && (v_count < V_CNT_W'(V_DISPLAY));
    assign x        = video_on ? X_W'(h_count) : '0;
    assign y        = video_on ? v_count[Y_W-1:0] : '0;

    assign hsync_raw = !((h_count >= H_CNT_W'(HS_FIRST)) && (h_count <= H_CNT_W'(HS_LAST)));
    assign vsync_raw = !((v_count >= V_CNT_W'(VS_FIRST)) && (v_count <= V_CNT_W'(VS_LAST)));

`ifdef VGA_SYNC_PIPE_EN
    logic [1:0] hsync_pipe;
    logic [1:0] vsync_pipe;

    // Two-stage delay so syncs match the ROM color latency; idle-high on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_pipe <= 2'b11;
            vsync_pipe <= 2'b11;
        end else begin
            hsync_pipe <= {hsync_pipe[0], hsync_raw};
            vsync_pipe <= {vsync_pipe[0], vsync_raw};
        end
    end

    assign hsync = hsync_pipe[1];
    assign vsync = vsync_pipe[1];
`else
    assign hsync = hsync_raw;
    assign vsync = vsync_raw;
`endif

endmodule
